axi_memtest_master: RTL and testbench

AXI_MEMTEST_MASTER -- requirements
Module: axi_memtest_master

---
 rtl/axi_memtest_master.sv | 175 +++++++++++++++++
 tb/tb_axi_memtest_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_memtest_master.sv
// AXI4 memory test master: writes a seed-XOR-index pattern over NUM_BURSTS bursts,
// reads it back, and reports mismatches (data or rlast position) with the first failing address.
module axi_memtest_master #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [7:0]  BURST_LEN  = 8'd63,
    parameter logic [15:0] NUM_BURSTS = 16'd16
) (
    input  logic                  clk,
    input  logic                  rstn_async,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  wlast,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast,
    input  logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned           BYTES       = DATA_WIDTH / 8;
    localparam int unsigned           BEATS       = int'(BURST_LEN) + 1;
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BEATS * BYTES);
    localparam logic [DATA_WIDTH-1:0] BEATS_D     = DATA_WIDTH'(BEATS);
    localparam logic [15:0]           LAST_BURST  = NUM_BURSTS - 16'd1;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n;
    state_t     state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q, addr_q, first_err_q;
    logic [DATA_WIDTH-1:0] seed_q, wdata_q, gbase_q;
    logic [7:0]            beat_q;
    logic [15:0]           burst_q, err_q;

    logic                  last_beat, last_burst, start_ok, rd_fire, rd_end, beat_bad;
    logic [DATA_WIDTH-1:0] exp_data;

    // Reset asserts immediately, releases two clocks after rstn_async rises.
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) rst_sync_q <= 2'b00;
        else             rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign last_beat  = (beat_q == BURST_LEN);
    assign last_burst = (burst_q == LAST_BURST);
    assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign exp_data   = seed_q ^ (gbase_q + DATA_WIDTH'(beat_q));
    assign rd_fire    = (state_q == S_R) && rvalid;
    assign rd_end     = rd_fire && (rlast || last_beat);
    assign beat_bad   = rd_fire && ((rdata != exp_data) || (rlast != last_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_AW;
            S_AW:           if (awready) state_d = S_W;
            S_W:            if (wready && last_beat) state_d = S_B;
            S_B:            if (bvalid) state_d = last_burst ? S_AR : S_AW;
            S_AR:           if (arready) state_d = S_R;
            S_R:            if (rd_end) state_d = last_burst ? S_DONE : S_AR;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            addr_q      <= '0;
            first_err_q <= '0;
            seed_q      <= '0;
            wdata_q     <= '0;
            gbase_q     <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            err_q       <= '0;
        end else if (start_ok) begin
            base_q      <= base_addr;
            addr_q      <= base_addr;
            seed_q      <= seed;
            wdata_q     <= seed;
            gbase_q     <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            case (state_q)
                S_W: if (wready) begin
                    if (last_beat) begin
                        beat_q <= '0;
                    end else begin
                        beat_q  <= beat_q + 8'd1;
                        wdata_q <= seed_q ^ (gbase_q + DATA_WIDTH'(beat_q) + DATA_WIDTH'(1));
                    end
                end
                // Burst bookkeeping advances on the write response; rewinds for the read pass.
                S_B: if (bvalid) begin
                    if (last_burst) begin
                        burst_q <= '0;
                        addr_q  <= base_q;
                        gbase_q <= '0;
                        wdata_q <= seed_q;
                    end else begin
                        burst_q <= burst_q + 16'd1;
                        addr_q  <= addr_q + BURST_BYTES;
                        gbase_q <= gbase_q + BEATS_D;
                        wdata_q <= seed_q ^ (gbase_q + BEATS_D);
                    end
                end
                S_R: if (rvalid) begin
                    if (beat_bad) begin
                        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                        if (err_q == 16'd0)
                            first_err_q <= addr_q + ADDR_WIDTH'(32'(beat_q) * BYTES);
                    end
                    if (rd_end) begin
                        beat_q <= '0;
                        if (!last_burst) begin
                            burst_q <= burst_q + 16'd1;
                            addr_q  <= addr_q + BURST_BYTES;
                            gbase_q <= gbase_q + BEATS_D;
                        end
                    end else begin
                        beat_q <= beat_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid/ready strobes decode the state alone; data and addresses come from registers.
    assign awvalid        = (state_q == S_AW);
    assign wvalid         = (state_q == S_W);
    assign wlast          = (state_q == S_W) && last_beat;
    assign bready         = (state_q == S_B);
    assign arvalid        = (state_q == S_AR);
    assign rready         = (state_q == S_R);
    assign awaddr         = addr_q;
    assign araddr         = addr_q;
    assign awlen          = BURST_LEN;
    assign arlen          = BURST_LEN;
    assign wdata          = wdata_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
endmodule

// File: tb/tb_axi_memtest_master.sv
// Bench for axi_memtest_master: ideal AXI memory responder, pattern model with expected queues,
// and directed scenarios for stalls, corruption, early rlast, throttling and mid-burst reset.
module tb_axi_memtest_master;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int BEATS = 4;
    localparam int NBURSTS = 2;

    logic clk, rstn_async, start;
    logic [AW-1:0] base_addr, awaddr, araddr, first_err_addr;
    logic [DW-1:0] seed, wdata, rdata;
    logic busy, done, pass, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic [15:0] err_count;
    logic [7:0] awlen, arlen;

    int checks = 0;
    int errors = 0;

    axi_memtest_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8'd3), .NUM_BURSTS(16'd2)) dut (
        .clk(clk), .rstn_async(rstn_async), .start(start), .base_addr(base_addr), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // responder knobs and state
    bit aw_block, wr_toggle, rd_toggle, early_rlast_en, corrupt_en, tog;
    logic [AW-1:0] corrupt_addr, rd_a;
    logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
    int wbeat, rbeat, pending_b, rd_bursts;
    logic [DW-1:0] mem [int];

    // scoreboard
    logic [AW-1:0] exp_aw_q[$], exp_ar_q[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] aw_log[$], ar_log[$];
    logic [DW-1:0] w_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_model(input logic [AW-1:0] base, input logic [DW-1:0] sd);
        exp_aw_q.delete(); exp_ar_q.delete(); exp_q.delete();
        for (int b = 0; b < NBURSTS; b++) begin
            exp_aw_q.push_back(base + AW'(b * BEATS * (DW / 8)));
            exp_ar_q.push_back(base + AW'(b * BEATS * (DW / 8)));
            for (int i = 0; i < BEATS; i++) exp_q.push_back(sd ^ DW'(b * BEATS + i));
        end
    endfunction

    function automatic void reset_responder();
        wr_addr_q.delete(); rd_addr_q.delete();
        wbeat = 0; rbeat = 0; pending_b = 0; rd_bursts = 0;
        aw_log.delete(); ar_log.delete(); w_log.delete();
    endfunction

    // responder + compare process: inputs set on negedge hold through the next posedge
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
        forever begin
            @(negedge clk);
            if (!rstn_async) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                continue;
            end
            tog = ~tog;
            awready = !aw_block;
            wready  = wr_toggle ? tog : 1'b1;
            bvalid  = (pending_b > 0);
            arready = 1'b1;
            if (rd_addr_q.size() > 0 && (!rd_toggle || tog)) begin
                rd_a   = rd_addr_q[0] + AW'(rbeat * (DW / 8));
                rdata  = mem.exists(int'(rd_a)) ? mem[int'(rd_a)] : '0;
                if (corrupt_en && rd_a == corrupt_addr) rdata = rdata ^ 16'h0001;
                rlast  = (rbeat == BEATS - 1) || (early_rlast_en && rd_bursts == 0 && rbeat == 1);
                rvalid = 1'b1;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; rdata = '0;
            end

            check("aw_ar_exclusive", awvalid && arvalid, 0);
            check("busy_done_exclusive", busy && done, 0);
            check("pass_rule", pass, done && err_count == 16'd0);

            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else check("awaddr", awaddr, exp_aw_q.pop_front());
                check("awlen", awlen, 8'd3);
                wr_addr_q.push_back(awaddr);
                aw_log.push_back(awaddr);
            end
            if (wvalid && wready) begin
                if (wr_addr_q.size() == 0) begin
                    check("w_before_aw", 1, 0);
                end else begin
                    if (exp_q.size() == 0) check("w_unexpected", 1, 0);
                    else check("wdata", wdata, exp_q.pop_front());
                    check("wlast", wlast, wbeat == BEATS - 1);
                    mem[int'(wr_addr_q[0] + AW'(wbeat * (DW / 8)))] = wdata;
                    w_log.push_back(wdata);
                    wbeat++;
                    if (wbeat == BEATS) begin
                        wbeat = 0;
                        void'(wr_addr_q.pop_front());
                        pending_b++;
                    end
                end
            end
            if (bvalid && bready) pending_b--;
            if (arvalid && arready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("araddr", araddr, exp_ar_q.pop_front());
                check("arlen", arlen, 8'd3);
                rd_addr_q.push_back(araddr);
                ar_log.push_back(araddr);
            end
            if (rvalid && rready) begin
                if (rlast) begin
                    rbeat = 0;
                    void'(rd_addr_q.pop_front());
                    rd_bursts++;
                end else begin
                    rbeat++;
                end
            end
        end
    end

    // driver tasks
    task automatic pulse_start(input logic [AW-1:0] b, input logic [DW-1:0] s);
        reset_responder();
        build_model(b, s);
        @(negedge clk);
        base_addr = b; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check("done_reached", done, 1);
        check("queues_drained", exp_q.size() + exp_aw_q.size() + exp_ar_q.size(), 0);
    endtask

    task automatic check_status(input string tag, input logic [15:0] e, input logic [AW-1:0] fa, input logic p);
        check({tag, "_err_count"}, err_count, e);
        check({tag, "_first_err_addr"}, first_err_addr, fa);
        check({tag, "_pass"}, pass, p);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rstn_async = 1'b0; start = 1'b0; base_addr = '0; seed = '0;
        aw_block = 0; wr_toggle = 0; rd_toggle = 0; early_rlast_en = 0; corrupt_en = 0; tog = 0;
        corrupt_addr = '0;
        reset_responder();
        repeat (3) @(negedge clk);
        check("rst_awvalid", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);
        check("rst_awaddr", awaddr, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_lens", {awlen, arlen}, 16'h0303);
        check("rst_status", {busy, done, pass}, 3'b000);
        check("rst_err", err_count, 0);
        check("rst_first_err", first_err_addr, 0);
        #2 rstn_async = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // basic pass with hand-computed pins on the model
        pulse_start(26'h100, 16'h00FF);
        wait_done(500);
        check_status("basic", 16'd0, 26'h0, 1'b1);
        check("basic_aw0", aw_log[0], 26'h100);
        check("basic_aw1", aw_log[1], 26'h108);
        check("basic_w0", w_log[0], 16'h00FF);
        check("basic_w1", w_log[1], 16'h00FE);
        check("basic_w2", w_log[2], 16'h00FD);
        check("basic_w3", w_log[3], 16'h00FC);
        check("basic_w4", w_log[4], 16'h00FB);
        check("basic_w7", w_log[7], 16'h00F8);

        // awready stalled 20 cycles, restart from DONE
        aw_block = 1;
        pulse_start(26'h2000, 16'hA5A5);
        for (int i = 0; i < 20; i++) begin
            check("stall_awvalid", awvalid, 1);
            check("stall_awaddr", awaddr, 26'h2000);
            check("stall_awlen", awlen, 8'd3);
            check("stall_no_w", wvalid, 0);
            @(negedge clk);
        end
        aw_block = 0;
        wait_done(500);
        check_status("stall", 16'd0, 26'h0, 1'b1);

        // corrupted read beat g=5
        corrupt_en = 1; corrupt_addr = 26'h10A;
        pulse_start(26'h100, 16'h00FF);
        wait_done(500);
        check_status("corrupt", 16'd1, 26'h10A, 1'b0);
        corrupt_en = 0;

        // early rlast on beat 1 of burst 0
        early_rlast_en = 1;
        pulse_start(26'h100, 16'h00FF);
        wait_done(500);
        check_status("early", 16'd1, 26'h102, 1'b0);
        check("early_ar1", ar_log[1], 26'h108);
        early_rlast_en = 0;

        // throttled wready/rvalid; start also clears the previous error count
        wr_toggle = 1; rd_toggle = 1;
        pulse_start(26'h3000, 16'h5A00);
        wait_done(1000);
        check_status("toggle", 16'd0, 26'h0, 1'b1);
        wr_toggle = 0; rd_toggle = 0;

        // reset during W, then restart
        pulse_start(26'h200, 16'h1234);
        for (int i = 0; i < 50 && !wvalid; i++) @(negedge clk);
        check("rst_mid_in_w", wvalid, 1);
        #3 rstn_async = 1'b0;
        #1;
        check("rst_mid_wvalid", wvalid, 0);
        check("rst_mid_awvalid", awvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_err", err_count, 0);
        reset_responder();
        repeat (3) @(negedge clk);
        #2 rstn_async = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(26'h200, 16'h1234);
        wait_done(500);
        check_status("restart", 16'd0, 26'h0, 1'b1);
        check("restart_aw0", aw_log[0], 26'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
